// File: rtl/bus_pkg.sv
// bus_pkg: field layout and FSM encoding for the snooping bus.
//   Bus message (cpu bus_out, snoop_msg), 10 bits:
//     [9] readMiss  [8] writeMiss  [7] invalidate  [6:4] address  [3:0] data
//   Bus response (cpu bus_in), 11 bits:
//     [10] ack  [9:4] zero  [3:0] data
// Shared by bus_controller, cpu and the cache snoop logic.
package bus_pkg;

  localparam int ACK_BIT = 10;
  localparam int RM_BIT  = 9;
  localparam int WM_BIT  = 8;
  localparam int INV_BIT = 7;
  localparam int ADDR_HI = 6;
  localparam int ADDR_LO = 4;
  localparam int DATA_HI = 3;

  localparam int MSG_W = 10;
  localparam int RSP_W = 11;

  // Width of a CPU index (supports up to 4 CPUs).
  localparam int IDX_W = 2;

  // Plain constants for the state register, plus an enum with the same
  // encoding for code that prefers a typed state.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SNOOP   = 2'd1;
  localparam logic [1:0] ST_COLLECT = 2'd2;
  localparam logic [1:0] ST_ACK     = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SNOOP   = ST_SNOOP,
    COLLECT = ST_COLLECT,
    ACK     = ST_ACK
  } bus_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among pending CPUs.
//   pending     in  NUM_CPU : request flags
//   last_grant  in  2       : index granted last; search starts one above
//   grant_valid out 1       : some request is pending
//   grant_idx   out 2       : chosen CPU (0 when grant_valid is 0)
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_CPU = 3
) (
  input  logic [NUM_CPU-1:0] pending,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx
);

  // Walk the offsets from farthest to nearest so the nearest pending CPU
  // after last_grant is the final (winning) assignment.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CPU; k >= 1; k--) begin
      int idx;
      idx = (int'(last_grant) + k) % NUM_CPU;
      if (pending[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_controller.sv
// bus_controller: shared snooping-bus controller.
// Captures each CPU's one-cycle bus_out message, grants round-robin,
// broadcasts the granted message to the snoopers, absorbs a write-back from
// a Modified owner into main memory, then acks the requester for one cycle.
//   clock        in  1              : rising-edge clock
//   reset_n      in  1              : asynchronous active-low reset
//   cpu_bus_out  in  NUM_CPU*10     : CPU i message at [10i+9:10i]
//   snoop_wb     in  NUM_CPU        : cache i supplies Modified data
//   snoop_data   in  NUM_CPU*DATA_W : write-back data per cache
//   cpu_bus_in   out NUM_CPU*11     : CPU i response at [11i+10:11i]
//   snoop_msg    out 10             : granted message (SNOOP cycle only)
//   snoop_valid  out 1              : snoop_msg valid
//   snoop_src    out 2              : requesting CPU (SNOOP cycle only)
//   busy         out 1              : state is not IDLE
//   coh_error    out 1              : sticky, two or more owners wrote back
//   dbg_state    out 2              : FSM state (ST_* encoding)
//   dbg_pending  out NUM_CPU        : captured-but-ungranted requests
// Handshake: a CPU pulses bus_out for one cycle; the controller holds the
// request in pending[i] until granted and answers with bus_in[10] high for
// exactly one cycle. A CPU must not re-issue before its ack; a message
// arriving while that CPU is already pending is dropped.
module bus_controller
  import bus_pkg::*;
#(
  parameter int NUM_CPU = 3,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_CPU*MSG_W-1:0]    cpu_bus_out,
  input  logic [NUM_CPU-1:0]          snoop_wb,
  input  logic [NUM_CPU*DATA_W-1:0]   snoop_data,
  output logic [NUM_CPU*RSP_W-1:0]    cpu_bus_in,
  output logic [MSG_W-1:0]            snoop_msg,
  output logic                        snoop_valid,
  output logic [IDX_W-1:0]            snoop_src,
  output logic                        busy,
  output logic                        coh_error,
  output logic [1:0]                  dbg_state,
  output logic [NUM_CPU-1:0]          dbg_pending
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [1:0]         state;
  logic [NUM_CPU-1:0] pending;
  logic [MSG_W-1:0]   req_msg [NUM_CPU];
  logic [MSG_W-1:0]   cur_msg;
  logic [IDX_W-1:0]   cur_src;
  logic [IDX_W-1:0]   last_grant;
  logic               coh_error_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_fire;

  rr_arbiter #(.NUM_CPU(NUM_CPU)) u_arb (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign grant_fire = (state == ST_IDLE) && grant_valid;

  // ---------------------------------------------------------------------
  // Write-back selection during COLLECT
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0]  cur_addr;
  logic [NUM_CPU-1:0] wb_masked;
  logic               wb_any;
  logic               wb_multi;
  logic [IDX_W-1:0]   wb_idx;
  logic [DATA_W-1:0]  wb_data;
  logic               inv_only;
  logic               wants_data;

  assign cur_addr   = cur_msg[ADDR_LO +: ADDR_W];
  // The requester never supplies its own miss.
  assign wb_masked  = snoop_wb & ~(NUM_CPU'(1) << cur_src);
  assign wb_any     = |wb_masked;
  // Clearing the lowest set bit leaves something iff two or more were set.
  assign wb_multi   = (wb_masked & (wb_masked - NUM_CPU'(1))) != '0;
  assign inv_only   = cur_msg[INV_BIT] & ~cur_msg[RM_BIT] & ~cur_msg[WM_BIT];
  assign wants_data = cur_msg[RM_BIT] | cur_msg[WM_BIT];

  always_comb begin
    wb_idx = '0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      if (wb_masked[i]) wb_idx = IDX_W'(i);
    end
  end

  assign wb_data = snoop_data[wb_idx*DATA_W +: DATA_W];

  // ---------------------------------------------------------------------
  // Sequential state: capture, FSM, memory
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      cur_msg     <= '0;
      cur_src     <= '0;
      last_grant  <= IDX_W'(NUM_CPU - 1);
      coh_error_q <= 1'b0;
      for (int i = 0; i < NUM_CPU; i++) req_msg[i] <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(i);
    end else begin
      // Capture runs in every state. A CPU being granted this edge was
      // already pending, so its new message (if any) is dropped.
      for (int i = 0; i < NUM_CPU; i++) begin
        if (grant_fire && (grant_idx == IDX_W'(i))) begin
          pending[i] <= 1'b0;
        end else if (!pending[i] &&
                     (|cpu_bus_out[i*MSG_W+INV_BIT +: 3])) begin
          pending[i] <= 1'b1;
          req_msg[i] <= cpu_bus_out[i*MSG_W +: MSG_W];
        end
      end

      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            cur_msg    <= req_msg[grant_idx];
            cur_src    <= grant_idx;
            last_grant <= grant_idx;
            state      <= ST_SNOOP;
          end
        end
        ST_SNOOP: begin
          state <= ST_COLLECT;
        end
        ST_COLLECT: begin
          if (wb_multi) coh_error_q <= 1'b1;
          if (wb_any && !inv_only) mem[cur_addr] <= wb_data;
          state <= ST_ACK;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rsp_data;

  // mem already holds any write-back by the time the ACK cycle reads it.
  assign rsp_data = wants_data ? mem[cur_addr] : '0;

  always_comb begin
    cpu_bus_in = '0;
    if (state == ST_ACK) begin
      cpu_bus_in[cur_src*RSP_W +: RSP_W] =
        {1'b1, {(RSP_W-1-DATA_W){1'b0}}, rsp_data};
    end
  end

  assign snoop_valid = (state == ST_SNOOP);
  assign snoop_msg   = snoop_valid ? cur_msg : '0;
  assign snoop_src   = snoop_valid ? cur_src : '0;
  assign busy        = (state != ST_IDLE);
  assign coh_error   = coh_error_q;
  assign dbg_state   = state;
  assign dbg_pending = pending;

endmodule

// File: tb/tb_bus_controller.sv
// Directed bench for bus_controller (NUM_CPU=3, ADDR_W=3, DATA_W=4).
module tb_bus_controller;
  import bus_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [29:0] cpu_bus_out;
  logic [2:0]  snoop_wb;
  logic [11:0] snoop_data;
  logic [32:0] cpu_bus_in;
  logic [9:0]  snoop_msg;
  logic        snoop_valid;
  logic [1:0]  snoop_src;
  logic        busy;
  logic        coh_error;
  logic [1:0]  dbg_state;
  logic [2:0]  dbg_pending;

  int checks   = 0;
  int failures = 0;

  bus_controller #(.NUM_CPU(3), .ADDR_W(3), .DATA_W(4)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cpu_bus_out (cpu_bus_out),
    .snoop_wb    (snoop_wb),
    .snoop_data  (snoop_data),
    .cpu_bus_in  (cpu_bus_in),
    .snoop_msg   (snoop_msg),
    .snoop_valid (snoop_valid),
    .snoop_src   (snoop_src),
    .busy        (busy),
    .coh_error   (coh_error),
    .dbg_state   (dbg_state),
    .dbg_pending (dbg_pending)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated transaction from CPU src, with an optional write-back
  // presented during COLLECT, checking every phase.
  task automatic txn(input string tag, input int src, input logic [9:0] msg,
                     input logic [2:0] wb, input logic [11:0] wdata,
                     input logic [10:0] ack_exp);
    logic [32:0] flat;
    cpu_bus_out = '0;
    cpu_bus_out[src*10 +: 10] = msg;
    tick();                                   // E0: captured
    cpu_bus_out = '0;
    chk({tag, ".pend"}, 64'(dbg_pending[src]), 64'd1);
    chk({tag, ".idle"}, 64'(dbg_state), 64'(ST_IDLE));
    tick();                                   // E1: SNOOP
    chk({tag, ".snoop_state"}, 64'(dbg_state), 64'(ST_SNOOP));
    chk({tag, ".snoop_valid"}, 64'(snoop_valid), 64'd1);
    chk({tag, ".snoop_msg"}, 64'(snoop_msg), 64'(msg));
    chk({tag, ".snoop_src"}, 64'(snoop_src), 64'(src));
    tick();                                   // E2: COLLECT
    chk({tag, ".collect_state"}, 64'(dbg_state), 64'(ST_COLLECT));
    snoop_wb   = wb;
    snoop_data = wdata;
    tick();                                   // E3: ACK
    snoop_wb   = '0;
    snoop_data = '0;
    flat = '0;
    flat[src*11 +: 11] = ack_exp;
    chk({tag, ".ack"}, 64'(cpu_bus_in), 64'(flat));
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    tick();                                   // E4: back to IDLE
    chk({tag, ".ack_drop"}, 64'(cpu_bus_in), 64'd0);
    chk({tag, ".back_idle"}, 64'(dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    reset_n     = 1'b0;
    cpu_bus_out = '0;
    snoop_wb    = '0;
    snoop_data  = '0;
    tick();
    tick();
    chk("rst.bus_in", 64'(cpu_bus_in), 64'd0);
    chk("rst.snoop_valid", 64'(snoop_valid), 64'd0);
    chk("rst.snoop_msg", 64'(snoop_msg), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.coh", 64'(coh_error), 64'd0);
    chk("rst.pending", 64'(dbg_pending), 64'd0);
    reset_n = 1'b1;
    tick();

    // CPU1 readMiss addr 5: memory holds its reset value 5.
    txn("t1_rm5", 1, 10'b1_0_0_101_0000, 3'b000, 12'h000, 11'b1_000000_0101);

    // CPU0 writeMiss addr 3, CPU2 owner supplies A.
    txn("t2_wm3", 0, 10'b0_1_0_011_0000, 3'b100, 12'hA00, 11'b1_000000_1010);
    chk("t2.coh", 64'(coh_error), 64'd0);
    txn("t2_rb3", 2, 10'b1_0_0_011_0000, 3'b000, 12'h000, 11'b1_000000_1010);

    // Simultaneous CPU0 (addr 1) and CPU2 (addr 4); last grant was CPU2.
    cpu_bus_out = {10'b1_0_0_100_0000, 10'd0, 10'b1_0_0_001_0000};
    tick();                                   // E0
    cpu_bus_out = '0;
    chk("t3.pend_both", 64'(dbg_pending), 64'b101);
    tick();                                   // E1
    chk("t3.first_src", 64'(snoop_src), 64'd0);
    chk("t3.pend_cpu2", 64'(dbg_pending), 64'b100);
    tick();                                   // E2
    tick();                                   // E3
    chk("t3.ack_cpu0", 64'(cpu_bus_in), 64'(11'b1_000000_0001));
    chk("t3.pend_held", 64'(dbg_pending), 64'b100);
    tick();                                   // E4
    chk("t3.gap_idle", 64'(dbg_state), 64'(ST_IDLE));
    tick();                                   // E5
    chk("t3.second_src", 64'(snoop_src), 64'd2);
    tick();                                   // E6
    chk("t3.no_early_ack", 64'(cpu_bus_in), 64'd0);
    tick();                                   // E7
    chk("t3.ack_cpu2", 64'(cpu_bus_in), 64'({11'b1_000000_0100, 22'd0}));
    tick();

    // CPU2 invalidate addr 6 while CPU1 offers 5: no write, ack data 0.
    txn("t4_inv6", 2, 10'b0_0_1_110_0000, 3'b010, 12'h050, 11'b1_000000_0000);
    txn("t4_rb6", 1, 10'b1_0_0_110_0000, 3'b000, 12'h000, 11'b1_000000_0110);

    // Two owners answer CPU0 readMiss addr 2: lowest index (CPU1, 9) wins.
    txn("t5_rm2", 0, 10'b1_0_0_010_0000, 3'b110, 12'hC90, 11'b1_000000_1001);
    chk("t5.coh_set", 64'(coh_error), 64'd1);
    txn("t5_rb2", 1, 10'b1_0_0_010_0000, 3'b000, 12'h000, 11'b1_000000_1001);
    chk("t5.coh_sticky", 64'(coh_error), 64'd1);

    // Reset during COLLECT with a write-back offered for addr 3.
    cpu_bus_out = '0;
    cpu_bus_out[9:0] = 10'b0_1_0_011_0000;
    tick();                                   // E0
    cpu_bus_out = '0;
    tick();                                   // E1 SNOOP
    tick();                                   // E2 COLLECT
    chk("t6.in_collect", 64'(dbg_state), 64'(ST_COLLECT));
    snoop_wb   = 3'b010;
    snoop_data = 12'h070;
    #2 reset_n = 1'b0;
    #1;
    chk("t6.busy", 64'(busy), 64'd0);
    chk("t6.pending", 64'(dbg_pending), 64'd0);
    chk("t6.coh_clr", 64'(coh_error), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6.no_ack", 64'(cpu_bus_in), 64'd0);
    end
    snoop_wb   = '0;
    snoop_data = '0;
    reset_n    = 1'b1;
    tick();
    chk("t6.idle", 64'(dbg_state), 64'(ST_IDLE));
    txn("t6_rb3", 0, 10'b1_0_0_011_0000, 3'b000, 12'h000, 11'b1_000000_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
